// File: rtl/png_pkg.sv
// Shared encodings and constants for the PNG stream sequencer.
package png_pkg;

   typedef enum logic [2:0] {
      StIdle, StSig, StIhdr, StSrgb, StIdat, StIend, StLast
   } state_e;

   typedef enum logic [1:0] {PhLen, PhTyp, PhDat, PhCrc} phase_e;

   localparam logic [63:0] PNG_SIG   = 64'h89504E470D0A1A0A;
   localparam logic [31:0] TYPE_IHDR = 32'h49484452;
   localparam logic [31:0] TYPE_SRGB = 32'h73524742;
   localparam logic [31:0] TYPE_IDAT = 32'h49444154;
   localparam logic [31:0] TYPE_IEND = 32'h49454E44;
   localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_POLY  = 32'hEDB88320;

   // Big-endian byte select: idx 0 is the most significant byte.
   function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [31:0] s;
      s = word << {idx, 3'b000};
      return s[31:24];
   endfunction

   function automatic logic [7:0] sig_byte(input logic [2:0] idx);
      logic [63:0] s;
      s = PNG_SIG << {idx, 3'b000};
      return s[63:56];
   endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational single-byte CRC32 step, reflected polynomial, LSB-first.
module crc32_byte
   import png_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] crc_o
);

   always_comb begin
      logic [31:0] c;
      c = crc_i ^ {24'h0, byte_i};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_o = c;
   end

endmodule

// File: rtl/png_stream_ctrl.sv
// PNG container sequencer: signature, IHDR, [sRGB], IDAT x N, IEND with on-the-fly CRC32.
// Define PNG_STREAM_CTRL_SRGB_EN to insert an sRGB chunk after IHDR.
module png_stream_ctrl
   import png_pkg::*;
#(
   parameter int unsigned IDAT_CHUNK_MAX = 8192,
   parameter logic [7:0]  BIT_DEPTH      = 8'd8,
   parameter logic [7:0]  COLOR_TYPE     = 8'd6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] w_i,
   input  logic [31:0] h_i,
   input  logic [31:0] idat_len_i,
   output logic        busy_o,
   output logic        done_o,
   input  logic        val_i,
   input  logic [7:0]  dat_i,
   output logic        rdy_o,
   output logic        val_o,
   output logic [7:0]  dat_o,
   output logic        lst_o,
   input  logic        rdy_i
);

   state_e      state_q, state_d, next_chunk;
   phase_e      phase_q, phase_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] dcnt_q, dcnt_d;
   logic [31:0] len_q, len_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] crc_q, crc_d, crc_next;
   logic [31:0] w_q, h_q;
   logic [31:0] len_now, typ_now;
   logic [7:0]  byte_d, dat_byte;
   logic        load, emit, lst_d, done_d;

   assign load   = !val_o || rdy_i;
   assign busy_o = (state_q != StIdle);
   assign rdy_o  = (state_q == StIdat) && (phase_q == PhDat) && load;

   crc32_byte u_crc (
      .crc_i  (crc_q),
      .byte_i (byte_d),
      .crc_o  (crc_next)
   );

   always_comb begin
      len_now    = 32'd0;
      typ_now    = TYPE_IEND;
      next_chunk = StLast;
      unique case (state_q)
         StIhdr: begin
            len_now = 32'd13;
            typ_now = TYPE_IHDR;
`ifdef PNG_STREAM_CTRL_SRGB_EN
            next_chunk = StSrgb;
`else
            next_chunk = StIdat;
`endif
         end
         StSrgb: begin
            len_now    = 32'd1;
            typ_now    = TYPE_SRGB;
            next_chunk = StIdat;
         end
         StIdat: begin
            len_now    = (rem_q > 32'(IDAT_CHUNK_MAX)) ? 32'(IDAT_CHUNK_MAX) : rem_q;
            typ_now    = TYPE_IDAT;
            next_chunk = (rem_q != 32'd0) ? StIdat : StIend;
         end
         default: ;
      endcase
   end

   always_comb begin
      dat_byte = 8'h00;
      if (state_q == StIdat) begin
         dat_byte = dat_i;
      end else if (state_q == StIhdr) begin
         if (dcnt_q < 32'd4)       dat_byte = be_byte(w_q, dcnt_q[1:0]);
         else if (dcnt_q < 32'd8)  dat_byte = be_byte(h_q, dcnt_q[1:0]);
         else if (dcnt_q == 32'd8) dat_byte = BIT_DEPTH;
         else if (dcnt_q == 32'd9) dat_byte = COLOR_TYPE;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bcnt_d  = bcnt_q;
      dcnt_d  = dcnt_q;
      len_d   = len_q;
      rem_d   = rem_q;
      crc_d   = crc_q;
      done_d  = 1'b0;
      emit    = 1'b0;
      lst_d   = 1'b0;
      byte_d  = 8'h00;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StSig;
               phase_d = PhLen;
               bcnt_d  = 2'd0;
               dcnt_d  = 32'd0;
               rem_d   = idat_len_i;
            end
         end
         StSig: begin
            emit   = 1'b1;
            byte_d = sig_byte(dcnt_q[2:0]);
            if (load) begin
               dcnt_d = dcnt_q + 32'd1;
               if (dcnt_q == 32'd7) begin
                  state_d = StIhdr;
                  dcnt_d  = 32'd0;
               end
            end
         end
         StLast: begin
            // Wait for the sink to take the final byte before signalling completion.
            if (val_o && rdy_i) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: begin
            unique case (phase_q)
               PhLen: begin
                  emit   = 1'b1;
                  byte_d = be_byte(len_now, bcnt_q);
                  if (load) begin
                     bcnt_d = bcnt_q + 2'd1;
                     if (bcnt_q == 2'd3) begin
                        phase_d = PhTyp;
                        len_d   = len_now;
                        crc_d   = CRC_INIT;
                     end
                  end
               end
               PhTyp: begin
                  emit   = 1'b1;
                  byte_d = be_byte(typ_now, bcnt_q);
                  if (load) begin
                     crc_d  = crc_next;
                     bcnt_d = bcnt_q + 2'd1;
                     if (bcnt_q == 2'd3) phase_d = (len_q == 32'd0) ? PhCrc : PhDat;
                  end
               end
               PhDat: begin
                  emit   = (state_q == StIdat) ? val_i : 1'b1;
                  byte_d = dat_byte;
                  if (load && emit) begin
                     crc_d  = crc_next;
                     dcnt_d = dcnt_q + 32'd1;
                     if (state_q == StIdat) rem_d = rem_q - 32'd1;
                     if (dcnt_q == len_q - 32'd1) begin
                        phase_d = PhCrc;
                        dcnt_d  = 32'd0;
                     end
                  end
               end
               PhCrc: begin
                  emit   = 1'b1;
                  byte_d = be_byte(~crc_q, bcnt_q);
                  lst_d  = (state_q == StIend) && (bcnt_q == 2'd3);
                  if (load) begin
                     bcnt_d = bcnt_q + 2'd1;
                     if (bcnt_q == 2'd3) begin
                        phase_d = PhLen;
                        state_d = next_chunk;
                     end
                  end
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         phase_q <= PhLen;
         bcnt_q  <= 2'd0;
         dcnt_q  <= 32'd0;
         len_q   <= 32'd0;
         rem_q   <= 32'd0;
         crc_q   <= CRC_INIT;
         w_q     <= 32'd0;
         h_q     <= 32'd0;
         done_o  <= 1'b0;
         val_o   <= 1'b0;
         dat_o   <= 8'h00;
         lst_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bcnt_q  <= bcnt_d;
         dcnt_q  <= dcnt_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         crc_q   <= crc_d;
         done_o  <= done_d;
         if (state_q == StIdle && start_i) begin
            w_q <= w_i;
            h_q <= h_i;
         end
         if (load) begin
            val_o <= emit;
            lst_o <= emit && lst_d;
            if (emit) dat_o <= byte_d;
         end
      end
   end

endmodule

// File: doc/png_stream_ctrl.md
Name: png_stream_ctrl

Overview:
- Top-level PNG container sequencer. Emits the complete PNG byte stream: signature, IHDR, optional sRGB, one or more IDAT chunks and IEND.
- IDAT payload is the compressed zlib stream from upstream, passed through and split into chunks of at most IDAT_CHUNK_MAX bytes.
- Each chunk's CRC32 is computed on the fly by the internal byte-step CRC sub-module. The block sits between the zlib packer and the output byte sink.

Parameters:
- IDAT_CHUNK_MAX, 8192, maximum IDAT data bytes per chunk (1..2^31-1).
- BIT_DEPTH, 8, IHDR bit-depth byte.
- COLOR_TYPE, 6, IHDR colour-type byte.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  frame start pulse; ignored while busy_o=1.
- w_i  in  32  image width, latched on start.
- h_i  in  32  image height, latched on start.
- idat_len_i  in  32  total zlib stream bytes, latched on start.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse after the last IEND byte is accepted.
- val_i  in  1  upstream byte valid.
- dat_i  in  8  upstream zlib byte.
- rdy_o  out  1  upstream ready.
- val_o  out  1  output byte valid.
- dat_o  out  8  output byte.
- lst_o  out  1  marks the final stream byte (last IEND CRC byte).
- rdy_i  in  1  downstream ready.

Behaviour:
- Reset values:
  - Outputs: busy_o, done_o, val_o, lst_o and rdy_o are 0; dat_o is 0x00.
  - Internal state: FSM in IDLE, all counters 0, CRC register 0xFFFFFFFF.
- Reset mid-frame aborts immediately. No partial-chunk recovery.
- Handshake:
  - Valid/ready on both sides. A transfer occurs when val&rdy are both high.
  - The output register holds dat_o/val_o/lst_o stable until rdy_i.
  - The output register loads when !val_o || rdy_i.
- Pass-through:
  - rdy_o = (state==IDAT_DAT) && (!val_o || rdy_i).
  - An accepted input byte appears on dat_o the next cycle (latency 1).
- Outer FSM:
  - IDLE -> SIG on start_i.
  - SIG emits 89 50 4E 47 0D 0A 1A 0A.
  - Then chunks in order: IHDR, [sRGB], IDAT x N, IEND.
  - Then done_o pulses, state returns to IDLE, busy_o=0.
- Chunk sub-FSM (per chunk): LEN (4 bytes, big-endian) -> TYP (4 ASCII bytes) -> DAT (len bytes, skipped if len=0) -> CRC (4 bytes, MSB first).
  - A 2-bit byte counter serves LEN/TYP/CRC; a 32-bit counter serves DAT.
- CRC:
  - Register is set to 0xFFFFFFFF on entering TYP.
  - Updated by crc32_byte on every emitted TYP/DAT byte at the output-load event.
  - Emitted value is ~crc.
- IHDR data (13 bytes): w(4), h(4), BIT_DEPTH, COLOR_TYPE, 0, 0, 0.
- IDAT split:
  - Chunk len = min(remaining, IDAT_CHUNK_MAX).
  - remaining decrements per accepted input byte.
  - The next IDAT chunk starts when remaining>0 after a CRC phase.
- idat_len_i=0: exactly one zero-length IDAT is emitted (00 00 00 00 49 44 41 54 35 AF 06 1E).
- Output stall: while rdy_i=0, no state, counter or CRC advances, and rdy_o=0.
- Upstream gaps: in IDAT_DAT with val_i=0, no output byte is produced and val_o drops after the pending byte drains.
- Upstream excess: bytes beyond idat_len_i are never accepted (rdy_o=0 outside IDAT_DAT).
- start_i while busy_o=1 is ignored. start_i in the done_o cycle is accepted (back-to-back frames).

Optional Feature:
- Macro PNG_STREAM_CTRL_SRGB_EN.
- Defined: an sRGB chunk is inserted between IHDR and the first IDAT: 00 00 00 01 73 52 47 42 00 AE CE 1C E9. Its CRC is computed by the engine, not a constant.
- Undefined: no sRGB chunk; IHDR is followed directly by IDAT.

Decomposition:
- Shared package png_pkg holds:
  - outer state and chunk-phase encodings;
  - PNG_SIG constant;
  - chunk type constants IHDR/sRGB/IDAT/IEND (32-bit ASCII);
  - CRC_INIT = 0xFFFFFFFF and CRC_POLY = 0xEDB88320.
- One sub-module: crc32_byte. Combinational 8-bit step: crc_i, byte_i -> crc_o, reflected polynomial 0xEDB88320.

Test Plan:
- 1x1, idat_len_i=0, rdy_i=1 -> 57-byte stream.
  - IHDR CRC bytes 1F 15 C4 89.
  - Empty IDAT CRC 35 AF 06 1E.
  - IEND bytes 00 00 00 00 49 45 4E 44 AE 42 60 82.
  - lst_o on byte 57; done_o one cycle later.
- IDAT_CHUNK_MAX=4, idat_len_i=10, bytes 0x00..0x09 -> three IDATs with lengths 4, 4, 2.
  - Each CRC matches the software model.
  - Total 8+25+3*12+10+12 = 91 bytes.
- Random rdy_i (50%) and val_i gaps, idat_len_i=1000 -> byte-exact match with the golden stream.
  - dat_o stable while val_o&!rdy_i.
  - No lost or duplicated bytes.
- Reset asserted during the IDAT DAT phase -> all outputs 0 next edge. A new start_i then produces a clean full stream.
- start_i pulsed while busy -> ignored; stream unchanged. start_i on the done_o cycle -> second frame begins with 89 50 4E 47.
- PNG_STREAM_CTRL_SRGB_EN defined, 1x1, len=0 -> sRGB chunk bytes exactly as specified, placed after IHDR; total 70 bytes.
